// File: rtl/sram_tiled_wrapper.sv
// sram_tiled_wrapper: DATA_WIDTH x DEPTH simple-dual-port memory assembled from
// a grid of 32x256 1rw1r macros. Port 0 of every macro only writes and port 1
// only reads. Adds byte masks, a registered read stage with a valid flag, output
// hold and write-first forwarding for same-address read/write collisions.
// DATA_WIDTH must be a multiple of 32, DEPTH a multiple of 256.

// Behavioural stand-in for the 32x256 macro. It registers its inputs at posedge,
// then writes the array and drives the read data on the following negedge.
module sky130_sram_1kbyte_1rw1r_32x256_8 (
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [7:0]  addr0,
    input  logic [31:0] din0,
    output logic [31:0] dout0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [7:0]  addr1,
    output logic [31:0] dout1
);
    logic [31:0] mem [256];

    logic        csb0_q;
    logic        web0_q;
    logic [3:0]  wmask0_q;
    logic [7:0]  addr0_q;
    logic [31:0] din0_q;
    logic        csb1_q;
    logic [7:0]  addr1_q;

    // capture port 0 controls at the rising edge
    always_ff @(posedge clk0) begin
        csb0_q   <= csb0;
        web0_q   <= web0;
        wmask0_q <= wmask0;
        addr0_q  <= addr0;
        din0_q   <= din0;
    end

    // capture port 1 controls at the rising edge
    always_ff @(posedge clk1) begin
        csb1_q  <= csb1;
        addr1_q <= addr1;
    end

    // byte-masked write on the falling edge
    always_ff @(negedge clk0) begin
        if (!csb0_q && !web0_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask0_q[b]) begin
                    mem[addr0_q][8*b +: 8] <= din0_q[8*b +: 8];
                end
            end
        end
    end

    // port 0 read data (present on the macro, unused by the wrapper)
    always_ff @(negedge clk0) begin
        if (!csb0_q && web0_q) begin
            dout0 <= mem[addr0_q];
        end
    end

    // port 1 read data on the falling edge
    always_ff @(negedge clk1) begin
        if (!csb1_q) begin
            dout1 <= mem[addr1_q];
        end
    end
endmodule

module sram_tiled_wrapper #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wadr,
    input  logic [NUM_WMASKS-1:0] wmask,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] radr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  rvalid
);
    localparam int NC = DATA_WIDTH / 32;
    localparam int NR = DEPTH / 256;
    // row index width; a single-row memory still carries a 1-bit row field
    localparam int RW = (ADDR_WIDTH > 8) ? ADDR_WIDTH - 8 : 1;
    localparam logic [RW:0] NR_L = NR[RW:0];

    logic [RW-1:0] w_row;
    logic [RW-1:0] r_row;
    logic          w_ok;
    logic          r_ok;
    logic          wr_go;
    logic          rd_go;

    logic [31:0]   mac_dout [NR][NC];

    // read-stage pipeline registers
    logic                  rd_pend_q,  rd_pend_d;
    logic [RW-1:0]         rd_row_q,   rd_row_d;
    logic                  rd_oor_q,   rd_oor_d;
    logic                  hit_q,      hit_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic [NUM_WMASKS-1:0] fwd_mask_q, fwd_mask_d;
    logic [DATA_WIDTH-1:0] q_q,        q_d;
    logic                  rvalid_q,   rvalid_d;

    logic [DATA_WIDTH-1:0] row_word;

    generate
        if (ADDR_WIDTH > 8) begin : g_multi_row
            assign w_row = wadr[ADDR_WIDTH-1:8];
            assign r_row = radr[ADDR_WIDTH-1:8];
        end else begin : g_single_row
            assign w_row = '0;
            assign r_row = '0;
        end
    endgenerate

    // Rows past NR exist only when DEPTH is not a power of two.
    assign w_ok = {1'b0, w_row} < NR_L;
    assign r_ok = {1'b0, r_row} < NR_L;

    // Holding reset keeps every chip select high so nothing is written.
    assign wr_go = rst_n && we && (wmask != '0) && w_ok;
    assign rd_go = rst_n && re && r_ok;

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_row
            logic csb0_row;
            logic csb1_row;

            assign csb0_row = !(wr_go && (w_row == RW'(gi)));
            assign csb1_row = !(rd_go && (r_row == RW'(gi)));

            for (genvar gj = 0; gj < NC; gj++) begin : g_col
                logic [31:0] dout0_unused;

                sky130_sram_1kbyte_1rw1r_32x256_8 u_macro (
                    .clk0   (clk),
                    .csb0   (csb0_row),
                    .web0   (csb0_row),
                    .wmask0 (wmask[4*gj +: 4]),
                    .addr0  (wadr[7:0]),
                    .din0   (d[32*gj +: 32]),
                    .dout0  (dout0_unused),
                    .clk1   (clk),
                    .csb1   (csb1_row),
                    .addr1  (radr[7:0]),
                    .dout1  (mac_dout[gi][gj])
                );
            end
        end
    endgenerate

    // register the row and collision record of an accepted read
    always_comb begin
        rd_pend_d  = re;
        rd_row_d   = rd_row_q;
        rd_oor_d   = rd_oor_q;
        hit_d      = hit_q;
        fwd_data_d = fwd_data_q;
        fwd_mask_d = fwd_mask_q;
        if (re) begin
            rd_row_d   = r_row;
            rd_oor_d   = !r_ok;
            hit_d      = we && (wadr == radr);
            fwd_data_d = d;
            fwd_mask_d = wmask;
        end
    end

    // select the addressed row's read data and overlay forwarded write bytes
    always_comb begin
        row_word = '0;
        for (int r = 0; r < NR; r++) begin
            if (rd_row_q == RW'(r)) begin
                for (int c = 0; c < NC; c++) begin
                    row_word[32*c +: 32] = mac_dout[r][c];
                end
            end
        end
        if (hit_q) begin
            for (int b = 0; b < NUM_WMASKS; b++) begin
                if (fwd_mask_q[b]) begin
                    row_word[8*b +: 8] = fwd_data_q[8*b +: 8];
                end
            end
        end
    end

    // capture stage: update q on a pending read, otherwise hold
    always_comb begin
        q_d      = q_q;
        rvalid_d = 1'b0;
        if (rd_pend_q) begin
            rvalid_d = 1'b1;
            q_d      = rd_oor_q ? '0 : row_word;
        end
    end

    // state registers; reset discards any pending read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_row_q   <= '0;
            rd_oor_q   <= 1'b0;
            hit_q      <= 1'b0;
            fwd_data_q <= '0;
            fwd_mask_q <= '0;
            q_q        <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_row_q   <= rd_row_d;
            rd_oor_q   <= rd_oor_d;
            hit_q      <= hit_d;
            fwd_data_q <= fwd_data_d;
            fwd_mask_q <= fwd_mask_d;
            q_q        <= q_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign q      = q_q;
    assign rvalid = rvalid_q;
endmodule
